countdown_controller: RTL and testbench
=======================================

// Module: countdown_controller
// PURPOSE
//  Sequencer for the N-bit down-counter (restador) on the FPGA board. Debounces the
//  load/start/pause push-buttons, issues load and decrement strobes to the counter at
//  a fixed tick rate, and stops cleanly at zero. Sits between the board buttons and
//  the counter. The counter value feeds back in on count; the counter never wraps.
// PARAMETERS
//  N               6        counter / init_value / count width
//  DEBOUNCE_CYCLES 500000   clocks a synced button level must be stable to be accepted
//  TICK_DIV        50000000 clocks between decrement strobes while running (>=2)
// PORTS
//  clk          in   1  system clock
//  reset        in   1  synchronous, active-high reset
//  load_btn     in   1  raw button, active-high after board inversion; async to clk
//  start_btn    in   1  raw button, active-high; async
//  pause_btn    in   1  raw button, active-high; async
//  init_value   in   N  switch value latched on load
//  count        in   N  current counter value, from the counter
//  load_pulse   out  1  1-cycle strobe: counter loads load_value
//  load_value   out  N  registered copy of init_value, captured on load event
//  dec_pulse    out  1  1-cycle strobe: counter decrements by 1
//  running      out  1  high in RUN
//  done         out  1  high in DONE (count reached 0)
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, prescaler 0, debounced levels 0, sync FFs 0.
//  Input path per button: 2-FF synchronizer -> debouncer. Debounced level changes only
//   after the synced level differs from it for DEBOUNCE_CYCLES consecutive clocks; any
//   bounce restarts the count. A rising edge of the debounced level = 1-cycle event.
//  Event priority in the same cycle: load > start > pause.
//  Outputs are registered: load_pulse/dec_pulse/state flags appear 1 cycle after cause.
//  States:
//   IDLE   load_ev: load_value<=init_value, load_pulse, stay IDLE.
//          start_ev: count!=0 -> RUN (prescaler cleared); count==0 -> DONE.
//   RUN    prescaler counts 0..TICK_DIV-1; at TICK_DIV-1 it wraps to 0 and, if count!=0,
//          dec_pulse for one cycle. First dec_pulse is TICK_DIV cycles after RUN entry.
//          count==0 (and no dec_pulse in flight) -> DONE next cycle; no dec_pulse at 0.
//          pause_ev -> PAUSED, prescaler holds its value.
//          load_ev -> load, IDLE, prescaler cleared.
//   PAUSED prescaler frozen; start_ev or pause_ev -> RUN, prescaler resumes from the held
//          value. load_ev -> load, IDLE.
//   DONE   done=1. start_ev/pause_ev ignored. load_ev -> load, IDLE.
//  In-flight rule: after dec_pulse, count is not re-checked for zero until the next
//   cycle, so the counter update is always observed.
//  reset mid-operation: returns to IDLE within 1 cycle; a pending strobe is dropped.
//  The counter is never driven below 0; no wrap-around at any N.
// TESTING  (sim params: N=6, DEBOUNCE_CYCLES=4, TICK_DIV=5)
//  1 load_btn held 10 clk with init=5 -> one load_pulse, load_value=5, state IDLE;
//    pulse 1 clk after 2 sync + 4 stable clocks.
//  2 Bounce: load_btn toggles every 2 clk for 12 clk, then stays low -> no load_pulse.
//  3 Load 3, start, model counter -> dec_pulse every 5 clk, exactly 3 pulses,
//    then done=1, running=0; no 4th pulse.
//  4 Start with count=0 -> DONE directly. No dec_pulse ever. start_btn again -> stays DONE.
//  5 RUN with prescaler at 2, pause -> no dec_pulse for 20 clk. Start ->
//    next dec_pulse after 3 more clk.
//  6 load_btn and start_btn debounced in the same cycle during RUN -> load_pulse, IDLE;
//    reset asserted during RUN -> all outputs 0 next cycle.

Source files
------------

// File: rtl/countdown_controller.sv
// Button-driven sequencer for an external down-counter: debounced load/start/pause,
// tick-rate decrement strobes, clean stop at zero.
module countdown_controller #(
  parameter int N               = 6,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int TICK_DIV        = 50000000
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load_btn,
  input  logic         start_btn,
  input  logic         pause_btn,
  input  logic [N-1:0] init_value,
  input  logic [N-1:0] count,
  output logic         load_pulse,
  output logic [N-1:0] load_value,
  output logic         dec_pulse,
  output logic         running,
  output logic         done
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int PW = $clog2(TICK_DIV);
  localparam logic [DW-1:0] DEB_RELOAD = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

  // bit 0 = load, bit 1 = start, bit 2 = pause
  logic [2:0] btn_raw, sync0, sync1, deb, deb_d, ev;

  assign btn_raw = {pause_btn, start_btn, load_btn};

  always_ff @(posedge clk) begin
    if (reset) begin
      sync0 <= '0;
      sync1 <= '0;
      deb_d <= '0;
    end else begin
      sync0 <= btn_raw;
      sync1 <= sync0;
      deb_d <= deb;
    end
  end

  // Level is accepted only after DEBOUNCE_CYCLES consecutive disagreeing samples.
  for (genvar i = 0; i < 3; i++) begin : g_deb
    logic [DW-1:0] timer;
    logic          level;

    always_ff @(posedge clk) begin
      if (reset) begin
        timer <= DEB_RELOAD;
        level <= 1'b0;
      end else if (sync1[i] == level) begin
        timer <= DEB_RELOAD;
      end else if (timer == '0) begin
        level <= sync1[i];
        timer <= DEB_RELOAD;
      end else begin
        timer <= timer - DW'(1);
      end
    end

    assign deb[i] = level;
  end

  assign ev = deb & ~deb_d;

  // state  | meaning
  // IDLE   | waiting for start, loads allowed
  // RUN    | prescaler running, decrement strobes issued
  // PAUSED | prescaler frozen
  // DONE   | count reached zero
  typedef enum logic [1:0] {IDLE, RUN, PAUSED, DONE} state_t;

  state_t        state, state_nxt;
  logic [PW-1:0] presc, presc_nxt;
  logic [N-1:0]  load_value_nxt;
  logic          load_pulse_nxt, dec_pulse_nxt;
  logic          at_zero;

  assign at_zero = (count == '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      presc      <= '0;
      load_pulse <= 1'b0;
      dec_pulse  <= 1'b0;
      load_value <= '0;
    end else begin
      state      <= state_nxt;
      presc      <= presc_nxt;
      load_pulse <= load_pulse_nxt;
      dec_pulse  <= dec_pulse_nxt;
      load_value <= load_value_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    presc_nxt      = presc;
    load_value_nxt = load_value;
    load_pulse_nxt = 1'b0;
    dec_pulse_nxt  = 1'b0;
    if (ev[0]) begin
      load_value_nxt = init_value;
      load_pulse_nxt = 1'b1;
      state_nxt      = IDLE;
      presc_nxt      = '0;
    end else begin
      case (state)
        IDLE: begin
          if (ev[1]) begin
            presc_nxt = '0;
            state_nxt = at_zero ? DONE : RUN;
          end
        end
        RUN: begin
          // While a strobe is in flight the counter has not updated yet.
          if (ev[2]) begin
            state_nxt = PAUSED;
          end else if (at_zero && !dec_pulse) begin
            state_nxt = DONE;
          end else if (presc == PRESC_LAST) begin
            presc_nxt     = '0;
            dec_pulse_nxt = !at_zero;
          end else begin
            presc_nxt = presc + PW'(1);
          end
        end
        PAUSED: begin
          if (ev[1] || ev[2]) state_nxt = RUN;
        end
        DONE: begin
          state_nxt = DONE;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  assign running = (state == RUN);
  assign done    = (state == DONE);

endmodule

// File: tb/tb_countdown_controller.sv
// Bench for countdown_controller: directed scenarios plus randomized buttons, every
// cycle compared against a behavioural model of the buttons, sequencer and counter.
module tb_countdown_controller;

  localparam int N    = 6;
  localparam int DEB  = 4;
  localparam int TDIV = 5;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         load_btn = 1'b0, start_btn = 1'b0, pause_btn = 1'b0;
  logic [N-1:0] init_value = '0;
  logic [N-1:0] cnt = '0;
  logic         load_pulse, dec_pulse, running, done;
  logic [N-1:0] load_value;

  countdown_controller #(.N(N), .DEBOUNCE_CYCLES(DEB), .TICK_DIV(TDIV)) dut (
    .clk(clk), .reset(reset),
    .load_btn(load_btn), .start_btn(start_btn), .pause_btn(pause_btn),
    .init_value(init_value), .count(cnt),
    .load_pulse(load_pulse), .load_value(load_value),
    .dec_pulse(dec_pulse), .running(running), .done(done)
  );

  always #5 clk = ~clk;

  // the external counter
  always @(posedge clk) begin
    if (load_pulse) cnt <= load_value;
    else if (dec_pulse && cnt != 0) cnt <= cnt - 6'd1;
  end

  int n_tests = 0, n_fail = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", tag, obs, exp, $time);
    end
  endtask

  // behavioural model
  localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_DONE = 3;
  int         m_state = M_IDLE, m_presc = 0, m_cnt = 0;
  bit         m_lp = 0, m_dp = 0;
  logic [5:0] m_lv = '0;
  bit [2:0]   m_s0 = '0, m_s1 = '0, m_lvl = '0, m_prev = '0;
  int         m_run[3] = '{0, 0, 0};

  task automatic model_step();
    bit [2:0] raw, ev;
    int nc;
    bit zero, old_dp;
    raw = {pause_btn, start_btn, load_btn};
    nc = m_cnt;
    if (m_lp) nc = int'(m_lv);
    else if (m_dp && nc > 0) nc = nc - 1;
    ev = m_lvl & ~m_prev;
    zero = (m_cnt == 0);
    old_dp = m_dp;
    m_lp = 0;
    m_dp = 0;
    if (reset) begin
      m_state = M_IDLE;
      m_presc = 0;
      m_lv = '0;
    end else if (ev[0]) begin
      m_lv = init_value;
      m_lp = 1;
      m_state = M_IDLE;
      m_presc = 0;
    end else if (m_state == M_IDLE) begin
      if (ev[1]) m_state = zero ? M_DONE : M_RUN;
    end else if (m_state == M_RUN) begin
      if (ev[2]) m_state = M_PAUSE;
      else if (zero && !old_dp) m_state = M_DONE;
      else begin
        m_presc = (m_presc + 1) % TDIV;
        if (m_presc == 0 && !zero) m_dp = 1;
      end
    end else if (m_state == M_PAUSE) begin
      if (ev[1] || ev[2]) m_state = M_RUN;
    end
    m_cnt = nc;
    if (reset) begin
      m_s0 = '0; m_s1 = '0; m_lvl = '0; m_prev = '0;
      for (int b = 0; b < 3; b++) m_run[b] = 0;
    end else begin
      m_prev = m_lvl;
      for (int b = 0; b < 3; b++) begin
        if (m_s1[b] != m_lvl[b]) begin
          m_run[b]++;
          if (m_run[b] >= DEB) begin
            m_lvl[b] = m_s1[b];
            m_run[b] = 0;
          end
        end else begin
          m_run[b] = 0;
        end
      end
      m_s1 = m_s0;
      m_s0 = raw;
    end
  endtask

  // observation accumulators for directed scenarios
  int obs_idx, obs_lp, obs_dp, first_lp, first_dp, last_dp;
  bit obs_run;

  task automatic clr_obs();
    obs_idx = 0; obs_lp = 0; obs_dp = 0; first_lp = 0; first_dp = 0; last_dp = 0;
    obs_run = 0;
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    @(negedge clk);
    check_val("cyc", 32'({load_pulse, dec_pulse, running, done, load_value}),
              32'({m_lp, m_dp, (m_state == M_RUN), (m_state == M_DONE), m_lv}));
    obs_idx++;
    if (load_pulse) begin
      obs_lp++;
      if (first_lp == 0) first_lp = obs_idx;
    end
    if (dec_pulse) begin
      obs_dp++;
      if (first_dp == 0) first_dp = obs_idx;
      last_dp = obs_idx;
    end
    if (running) obs_run = 1;
  endtask

  task automatic press_load(input logic [5:0] v);
    init_value = v;
    load_btn = 1'b1;
    repeat (8) cycle();
    load_btn = 1'b0;
    repeat (10) cycle();
  endtask

  task automatic press_start();
    start_btn = 1'b1;
    repeat (8) cycle();
    start_btn = 1'b0;
    repeat (10) cycle();
  endtask

  int hold[3];

  initial begin
    clr_obs();
    repeat (2) cycle();
    check_val("rst_outs", 32'({load_pulse, dec_pulse, running, done, load_value}), 0);
    reset = 1'b0;

    // 1: clean load
    clr_obs();
    init_value = 6'd5;
    load_btn = 1'b1;
    repeat (10) cycle();
    load_btn = 1'b0;
    repeat (10) cycle();
    check_val("t1_npulse", obs_lp, 1);
    check_val("t1_lat", first_lp, 7);
    check_val("t1_val", load_value, 5);
    check_val("t1_flags", {running, done}, 0);

    // 2: bouncing load button
    clr_obs();
    init_value = 6'd9;
    for (int k = 0; k < 6; k++) begin
      load_btn = (k % 2 == 0);
      repeat (2) cycle();
    end
    load_btn = 1'b0;
    repeat (12) cycle();
    check_val("t2_npulse", obs_lp, 0);
    check_val("t2_val", load_value, 5);

    // 3: run 3 down to zero
    press_load(6'd3);
    clr_obs();
    start_btn = 1'b1;
    repeat (8) cycle();
    start_btn = 1'b0;
    repeat (32) cycle();
    check_val("t3_ndec", obs_dp, 3);
    check_val("t3_first", first_dp, 12);
    check_val("t3_last", last_dp, 22);
    check_val("t3_done", done, 1);
    check_val("t3_run", running, 0);
    check_val("t3_cnt", cnt, 0);

    // 4: start with count 0
    press_load(6'd0);
    clr_obs();
    press_start();
    check_val("t4_done", done, 1);
    press_start();
    check_val("t4_done2", done, 1);
    check_val("t4_ndec", obs_dp, 0);
    check_val("t4_run", obs_run, 0);

    // 5: pause with prescaler at 2, then resume
    press_load(6'd10);
    clr_obs();
    start_btn = 1'b1;
    repeat (3) cycle();
    pause_btn = 1'b1;
    repeat (10) cycle();
    start_btn = 1'b0;
    pause_btn = 1'b0;
    repeat (20) cycle();
    check_val("t5_ndec_paused", obs_dp, 0);
    check_val("t5_was_run", obs_run, 1);
    check_val("t5_flags", {running, done}, 0);
    clr_obs();
    start_btn = 1'b1;
    repeat (12) cycle();
    check_val("t5_resume_lat", first_dp, 10);
    check_val("t5_ndec", obs_dp, 1);
    check_val("t5_run", running, 1);

    // 6: load and start together in RUN, then reset in RUN
    start_btn = 1'b0;
    repeat (10) cycle();
    clr_obs();
    init_value = 6'd7;
    load_btn = 1'b1;
    start_btn = 1'b1;
    repeat (9) cycle();
    load_btn = 1'b0;
    start_btn = 1'b0;
    repeat (10) cycle();
    check_val("t6_npulse", obs_lp, 1);
    check_val("t6_lat", first_lp, 7);
    check_val("t6_val", load_value, 7);
    check_val("t6_flags", {running, done}, 0);
    start_btn = 1'b1;
    for (int k = 0; k < 20 && !running; k++) cycle();
    check_val("t6_run_wait", running, 1);
    repeat (4) cycle();
    reset = 1'b1;
    start_btn = 1'b0;
    cycle();
    check_val("t6_rst_outs", 32'({load_pulse, dec_pulse, running, done, load_value}), 0);
    reset = 1'b0;

    // randomized buttons, checked every cycle against the model
    for (int b = 0; b < 3; b++) hold[b] = $urandom_range(1, 12);
    for (int c = 0; c < 3000; c++) begin
      for (int b = 0; b < 3; b++) begin
        hold[b]--;
        if (hold[b] <= 0) begin
          hold[b] = $urandom_range(1, 12);
          case (b)
            0: load_btn = ~load_btn;
            1: start_btn = ~start_btn;
            default: pause_btn = ~pause_btn;
          endcase
        end
      end
      if (c % 50 == 0) init_value = 6'($urandom_range(0, 15));
      reset = ($urandom_range(0, 499) == 0);
      cycle();
    end
    reset = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
